// File: rtl/ball_dir_ctrl_pkg.sv
// Shared types and constants for the ball direction controller:
// FSM state encoding, default playfield limits and LFSR seed/taps.
package ball_dir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2
    } ball_state_t;

    localparam int X_MAX_DEF = 159;
    localparam int Y_MAX_DEF = 119;

    // x^8 + x^6 + x^5 + x^4 + 1 maps to state bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ball_dir_ctrl_if.sv
// Bundle of game-control inputs and direction/bounce outputs between the
// ball direction controller (slave) and its surrounding game logic (master).
interface ball_dir_ctrl_if;

    logic        tick;
    logic        run;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        dir_x;
    logic        dir_y;
    logic        ball_run;
    logic        bounce;
    logic [15:0] bounce_count;
    logic        beep;

    modport master (
        output tick, run, x, y,
        input  dir_x, dir_y, ball_run, bounce, bounce_count, beep
    );

    modport slave (
        input  tick, run, x, y,
        output dir_x, dir_y, ball_run, bounce, bounce_count, beep
    );

endinterface

// File: rtl/ball_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the serve direction.
// Seeded non-zero and primitive taps, so it never reaches the all-zero state.
module ball_lfsr
    import ball_dir_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] state
);

    logic [7:0] state_reg;
    logic [7:0] state_next;
    logic [7:0] tap_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tap
            assign tap_bits[gi] = state_reg[gi] & LFSR_TAPS[gi];
        end
    endgenerate

    assign state_next = {state_reg[6:0], ^tap_bits};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LFSR_SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction controller: IDLE/SERVE/PLAY sequencing, wall bounce detection
// and bounce counting. Define BALL_BEEP_EN to build the tick-timed beep output.
module ball_dir_ctrl
    import ball_dir_ctrl_pkg::*;
#(
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MAX       = Y_MAX_DEF,
    parameter int SERVE_TICKS = 30,
    parameter int BEEP_TICKS  = 4
) (
    input  logic           clk,
    input  logic           reset,
    ball_dir_ctrl_if.slave bus
);

    localparam int                   SERVE_W    = $clog2(SERVE_TICKS + 1);
    localparam logic [SERVE_W-1:0]   SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
    localparam logic [7:0]           X_LIM      = 8'(X_MAX);
    localparam logic [7:0]           Y_LIM      = 8'(Y_MAX);

    ball_state_t        state_reg;
    ball_state_t        state_next;
    logic [SERVE_W-1:0] serve_cnt_reg;
    logic               dir_x_reg;
    logic               dir_y_reg;
    logic               bounce_reg;
    logic [15:0]        bounce_count_reg;

    logic [7:0]         lfsr_state;
    logic               unused_lfsr_bits;
    logic               serve_done;
    logic               wall_en;
    logic               ball_run;
    logic               flip_x;
    logic               flip_y;
    logic               bounce_event;

    ball_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_state)
    );

    assign unused_lfsr_bits = ^lfsr_state[7:2];

    assign serve_done = (state_reg == SERVE) && bus.run && bus.tick
                        && (serve_cnt_reg == SERVE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.run) state_next = SERVE;
            SERVE:   if (serve_done) state_next = PLAY;
            PLAY:    state_next = PLAY;
            default: state_next = IDLE;
        endcase
        if (!bus.run) begin
            state_next = IDLE;
        end
    end

    // Walls are only live while playing and not being dropped out by run=0.
    always_comb begin
        ball_run = 1'b0;
        wall_en  = 1'b0;
        if (state_reg == PLAY) begin
            ball_run = 1'b1;
            wall_en  = bus.run;
        end
    end

    // x > LIM catches underflow wrap while travelling left.
    assign flip_x = wall_en && (dir_x_reg ? (bus.x == X_LIM)
                                          : ((bus.x == 8'd0) || (bus.x > X_LIM)));
    assign flip_y = wall_en && (dir_y_reg ? (bus.y == Y_LIM)
                                          : ((bus.y == 8'd0) || (bus.y > Y_LIM)));
    assign bounce_event = flip_x | flip_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            serve_cnt_reg    <= '0;
            dir_x_reg        <= 1'b1;
            dir_y_reg        <= 1'b1;
            bounce_reg       <= 1'b0;
            bounce_count_reg <= 16'd0;
        end else begin
            if (state_reg != SERVE) begin
                serve_cnt_reg <= '0;
            end else if (bus.tick) begin
                serve_cnt_reg <= serve_cnt_reg + SERVE_W'(1);
            end

            if (serve_done) begin
                dir_x_reg <= lfsr_state[0];
                dir_y_reg <= lfsr_state[1];
            end else begin
                if (flip_x) dir_x_reg <= ~dir_x_reg;
                if (flip_y) dir_y_reg <= ~dir_y_reg;
            end

            bounce_reg <= bounce_event;
            if (bounce_event && (bounce_count_reg != 16'hFFFF)) begin
                bounce_count_reg <= bounce_count_reg + 16'd1;
            end
        end
    end

    assign bus.dir_x        = dir_x_reg;
    assign bus.dir_y        = dir_y_reg;
    assign bus.ball_run     = ball_run;
    assign bus.bounce       = bounce_reg;
    assign bus.bounce_count = bounce_count_reg;

`ifdef BALL_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_TICKS + 1);

    logic [BEEP_W-1:0] beep_cnt_reg;

    // A fresh bounce reloads the full duration even if a beep is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            beep_cnt_reg <= '0;
        end else if (bounce_event) begin
            beep_cnt_reg <= BEEP_W'(BEEP_TICKS);
        end else if (bus.tick && (beep_cnt_reg != '0)) begin
            beep_cnt_reg <= beep_cnt_reg - BEEP_W'(1);
        end
    end

    assign bus.beep = (beep_cnt_reg != '0);
`else
    localparam int unused_beep_ticks = BEEP_TICKS;

    assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Self-checking bench for ball_dir_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural game model.
module tb_ball_dir_ctrl;

    localparam int XM = 159;
    localparam int YM = 119;
    localparam int ST = 30;
    localparam int BT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ball_dir_ctrl_if bus ();

    ball_dir_ctrl #(
        .X_MAX       (XM),
        .Y_MAX       (YM),
        .SERVE_TICKS (ST),
        .BEEP_TICKS  (BT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 idle, 1 serving, 2 playing.
    int         m_mode   = 0;
    int         m_ticks  = 0;
    bit         m_dx     = 1'b1;
    bit         m_dy     = 1'b1;
    bit         m_bounce = 1'b0;
    int         m_count  = 0;
    int         m_beep   = 0;
    logic [7:0] m_lfsr   = 8'hA5;
    bit         m_valid  = 1'b0;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] nl;
        bit fx;
        bit fy;
        nl = lfsr_adv(m_lfsr);
        fx = 1'b0;
        fy = 1'b0;
        if (reset) begin
            m_mode = 0; m_ticks = 0; m_dx = 1'b1; m_dy = 1'b1;
            m_bounce = 1'b0; m_count = 0; m_beep = 0; m_lfsr = 8'hA5;
            m_valid = 1'b1;
        end else begin
            m_bounce = 1'b0;
            if (!bus.run) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode  = 1;
                m_ticks = 0;
            end else if (m_mode == 1) begin
                if (bus.tick) begin
                    m_ticks++;
                    if (m_ticks == ST) begin
                        m_mode = 2;
                        m_dx   = m_lfsr[0];
                        m_dy   = m_lfsr[1];
                    end
                end
            end else begin
                fx = m_dx ? (int'(bus.x) == XM) : (bus.x == 8'd0 || int'(bus.x) > XM);
                fy = m_dy ? (int'(bus.y) == YM) : (bus.y == 8'd0 || int'(bus.y) > YM);
                if (fx) m_dx = !m_dx;
                if (fy) m_dy = !m_dy;
                if (fx || fy) begin
                    m_bounce = 1'b1;
                    if (m_count < 65535) m_count++;
                end
            end
            if (fx || fy) m_beep = BT;
            else if (bus.tick && m_beep > 0) m_beep--;
            m_lfsr = nl;
        end
    endtask

    // Single compare process: check current outputs, then advance the model
    // with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("dir_x", 32'(bus.dir_x), 32'(m_dx));
            chk("dir_y", 32'(bus.dir_y), 32'(m_dy));
            chk("ball_run", 32'(bus.ball_run), 32'(m_mode == 2));
            chk("bounce", 32'(bus.bounce), 32'(m_bounce));
            chk("bounce_count", 32'(bus.bounce_count), 32'(m_count));
`ifdef BALL_BEEP_EN
            chk("beep", 32'(bus.beep), 32'(m_beep > 0));
`else
            chk("beep", 32'(bus.beep), 32'd0);
`endif
        end
        model_step();
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
    endtask

    task automatic ticks_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick_pulse();
            cyc(2);
        end
    endtask

    // Assumes run=1 and the DUT in IDLE.
    task automatic serve_to_play();
        cyc(1);
        for (int i = 1; i <= ST; i++) begin
            tick_pulse();
            if (i == ST - 1) chk("serve_wait_ball_run", 32'(bus.ball_run), 32'd0);
            if (i < ST) cyc(2);
        end
        chk("serve_done_ball_run", 32'(bus.ball_run), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dir_x"}, 32'(bus.dir_x), 32'd1);
        chk({tag, "_dir_y"}, 32'(bus.dir_y), 32'd1);
        chk({tag, "_ball_run"}, 32'(bus.ball_run), 32'd0);
        chk({tag, "_bounce"}, 32'(bus.bounce), 32'd0);
        chk({tag, "_count"}, 32'(bus.bounce_count), 32'd0);
        chk({tag, "_beep"}, 32'(bus.beep), 32'd0);
    endtask

    function automatic logic [7:0] pick(input int lim);
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 8'd0;
            1:       return 8'(lim);
            2:       return 8'd255;
            3:       return 8'(lim + 1);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    int base;
    bit ptick;

    initial begin
        bus.run  = 1'b0;
        bus.tick = 1'b0;
        bus.x    = 8'd80;
        bus.y    = 8'd60;
        cyc(3);
        chk_reset_vals("reset");
        $display("txn reset: defaults checked");

        reset   = 1'b0;
        bus.run = 1'b1;
        serve_to_play();
        $display("txn serve: %0d ticks to play", ST);

        bus.x = 8'd0; bus.y = 8'd0;
        cyc(2);
        chk("steer_dir_x", 32'(bus.dir_x), 32'd1);
        chk("steer_dir_y", 32'(bus.dir_y), 32'd1);
        bus.x = 8'd80; bus.y = 8'd60;
        cyc(1);

        base  = m_count;
        bus.x = 8'(XM);
        cyc(1);
        chk("right_wall_dir_x", 32'(bus.dir_x), 32'd0);
        chk("right_wall_bounce", 32'(bus.bounce), 32'd1);
        chk("right_wall_count", 32'(bus.bounce_count), 32'(base + 1));
        repeat (4) begin
            cyc(1);
            chk("wall_hold_bounce", 32'(bus.bounce), 32'd0);
        end
        chk("wall_hold_count", 32'(bus.bounce_count), 32'(base + 1));
        $display("txn right wall: single bounce while held");

        base  = m_count;
        bus.x = 8'd255;
        cyc(1);
        chk("underflow_dir_x", 32'(bus.dir_x), 32'd1);
        chk("underflow_bounce", 32'(bus.bounce), 32'd1);
        chk("underflow_count", 32'(bus.bounce_count), 32'(base + 1));
        bus.x = 8'd80;
        cyc(1);
        $display("txn underflow: dir_x reversed");

        bus.x = 8'(XM); bus.y = 8'(YM);
        cyc(2);
        chk("far_corner_dir_x", 32'(bus.dir_x), 32'd0);
        chk("far_corner_dir_y", 32'(bus.dir_y), 32'd0);
        base  = m_count;
        bus.x = 8'd0; bus.y = 8'd0;
        cyc(1);
        chk("corner_dir_x", 32'(bus.dir_x), 32'd1);
        chk("corner_dir_y", 32'(bus.dir_y), 32'd1);
        chk("corner_bounce", 32'(bus.bounce), 32'd1);
        chk("corner_count", 32'(bus.bounce_count), 32'(base + 1));
        bus.x = 8'd80; bus.y = 8'd60;
        cyc(1);
        chk("corner_after_bounce", 32'(bus.bounce), 32'd0);
        $display("txn corner: both flipped, one count");

`ifdef BALL_BEEP_EN
        bus.x = 8'(XM);
        cyc(1);
        bus.x = 8'd80;
        chk("beep_rise", 32'(bus.beep), 32'd1);
        ticks_gap(3);
        chk("beep_hold3", 32'(bus.beep), 32'd1);
        ticks_gap(1);
        chk("beep_fall", 32'(bus.beep), 32'd0);
        bus.x = 8'd0;
        cyc(1);
        bus.x = 8'd80;
        ticks_gap(2);
        bus.x = 8'(XM);
        cyc(1);
        bus.x = 8'd80;
        ticks_gap(3);
        chk("beep_restart_hold", 32'(bus.beep), 32'd1);
        ticks_gap(1);
        chk("beep_restart_fall", 32'(bus.beep), 32'd0);
        $display("txn beep: duration and restart");
`else
        chk("beep_off", 32'(bus.beep), 32'd0);
`endif

        bus.run = 1'b0;
        cyc(1);
        chk("run_drop_play", 32'(bus.ball_run), 32'd0);
        bus.run = 1'b1;
        cyc(1);
        ticks_gap(2);
        bus.run = 1'b0;
        cyc(1);
        chk("run_drop_serve", 32'(bus.ball_run), 32'd0);
        cyc(1);
        bus.run = 1'b1;
        serve_to_play();
        bus.x = 8'd0; bus.y = 8'd0;
        reset = 1'b1;
        cyc(1);
        chk_reset_vals("reset_play");
        reset = 1'b0;
        bus.x = 8'd80; bus.y = 8'd60;
        $display("txn run drop and reset in play");

        for (int c = 0; c < 6000; c++) begin
            ptick = bus.tick;
            reset = ($urandom_range(0, 2499) == 0);
            if ($urandom_range(0, 699) == 0) bus.run = ~bus.run;
            else if (!bus.run && $urandom_range(0, 19) == 0) bus.run = 1'b1;
            bus.tick = !ptick && ($urandom_range(0, 2) == 0);
            bus.x = pick(XM);
            bus.y = pick(YM);
            cyc(1);
            if (c % 1000 == 999) $display("txn random segment to cycle %0d", c + 1);
        end

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_dir_ctrl.md
BALL_DIR_CTRL -- requirements
Module: ball_dir_ctrl

Interface
REQ-001 Parameter X_MAX, default 159, right-wall X in 4-pixel units.
REQ-002 Parameter Y_MAX, default 119, bottom-wall Y in 4-pixel units.
REQ-003 Parameter SERVE_TICKS, default 30, frame ticks spent in SERVE before motion.
REQ-004 Parameter BEEP_TICKS, default 4, frame ticks beep stays high per bounce.
REQ-005 clk  input  1  system clock; sole clock of the block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tick  input  1  frame tick, one-clk-wide pulse, at least 2 clk apart.
REQ-008 run  input  1  game enable; low forces IDLE.
REQ-009 x  input  8  current ball X from the ball stage.
REQ-010 y  input  8  current ball Y from the ball stage.
REQ-011 dir_x  output  1  0 = left, 1 = right; feeds the ball stage.
REQ-012 dir_y  output  1  0 = up, 1 = down; feeds the ball stage.
REQ-013 ball_run  output  1  motion enable to the ball stage; high only in PLAY.
REQ-014 bounce  output  1  one-clk pulse per bounce event.
REQ-015 bounce_count  output  16  total bounce events since reset, saturating.
REQ-016 beep  output  1  audible bounce indicator (see Configuration).

Function
REQ-017 FSM states IDLE, SERVE, PLAY; all transitions registered on clk.
REQ-018 IDLE -> SERVE when run=1; serve tick counter cleared on entry.
REQ-019 SERVE counts tick pulses; on the SERVE_TICKS-th tick -> PLAY, loading dir_x=lfsr[0], dir_y=lfsr[1] in the same cycle.
REQ-020 Any state -> IDLE in the cycle after run=0; dir_x/dir_y hold, ball_run=0 from that cycle.
REQ-021 8-bit LFSR free-runs every clk, seed 8'hA5, taps x^8+x^6+x^5+x^4+1; never all-zero.
REQ-022 PLAY, X right wall: x>=X_MAX and x<=X_MAX, dir_x=1 -> dir_x<=0 next clk.
REQ-023 PLAY, X left wall / underflow: (x==0 or x>X_MAX), dir_x=0 -> dir_x<=1 next clk.
REQ-024 Y walls identical to REQ-022/023 using y, Y_MAX, dir_y.
REQ-025 Wall check is evaluated every clk, not only on tick; a direction already pointing away from a wall is not flipped.
REQ-026 X and Y flips in the same cycle (corner): both flip, single bounce pulse, bounce_count +1.
REQ-027 bounce asserts for exactly the clk in which any flip is registered; bounce_count increments same edge, holds at 16'hFFFF.
REQ-028 Latency x/y change -> dir update: 1 clk; valid before next tick by REQ-007.
REQ-029 No wall evaluation in IDLE or SERVE.

Reset
REQ-030 reset in any state: state=IDLE, dir_x=1, dir_y=1, ball_run=0, bounce=0, bounce_count=0, beep=0, serve and beep counters=0, lfsr=8'hA5.
REQ-031 reset dominates run, tick and wall events in the same cycle.

Configuration
REQ-032 Macro BALL_BEEP_EN defined: beep rises with bounce, stays high for BEEP_TICKS tick pulses, a new bounce restarts the count.
REQ-033 BALL_BEEP_EN undefined: beep tied 0, beep counter not instantiated; all other behaviour identical.

Structure
REQ-034 Shared package holds FSM state enum (IDLE/SERVE/PLAY), default X_MAX/Y_MAX, LFSR seed and tap constants.
REQ-035 LFSR is a sub-module ball_lfsr (clk, reset, 8-bit state out); the remainder stays flat.

Verification
REQ-036 reset, run=1, 30 ticks -> ball_run rises on 30th tick, dir_x/dir_y equal lfsr[0]/lfsr[1] at that edge.
REQ-037 PLAY, dir_x=1, x=159 -> next clk dir_x=0, bounce one clk, bounce_count 0->1.
REQ-038 PLAY, dir_x=0, dir_y=0, x=0, y=0 -> both dirs 1 next clk, single bounce, count +1.
REQ-039 PLAY, dir_x=0, x=255 (underflow) -> dir_x=1; dir_x=1, x=159 held 5 clks -> exactly one bounce.
REQ-040 run dropped mid-SERVE and mid-PLAY -> IDLE next clk, ball_run=0; reset mid-PLAY -> all REQ-030 values.
REQ-041 BALL_BEEP_EN defined, bounce then 4 ticks -> beep high then low; bounce after 2 ticks -> beep extends 4 ticks from second bounce; undefined -> beep constant 0.
